// File: rtl/mmc1_pkg.sv
// Shared types and reset constants for the MMC1 cartridge mapper.
package mmc1_pkg;

    typedef enum logic [1:0] {
        REG_CONTROL = 2'd0,
        REG_CHR0    = 2'd1,
        REG_CHR1    = 2'd2,
        REG_PRG     = 2'd3
    } reg_idx_e;

    typedef enum logic [1:0] {
        MIR_ONE_LOW    = 2'd0,
        MIR_ONE_HIGH   = 2'd1,
        MIR_VERTICAL   = 2'd2,
        MIR_HORIZONTAL = 2'd3
    } mirror_e;

    typedef enum logic [1:0] {
        PRG_32K_A     = 2'd0,
        PRG_32K_B     = 2'd1,
        PRG_FIX_FIRST = 2'd2,
        PRG_FIX_LAST  = 2'd3
    } prg_mode_e;

    localparam logic [4:0] SHIFT_INIT   = 5'b10000;
    localparam logic [4:0] CONTROL_INIT = 5'h0C;

endpackage

// File: rtl/mmc1_sync_edge.sv
// Multi-flop synchronizer for an asynchronous strobe with registered level and
// one-clock rise/fall events; also suits PPU_RD and SPI_CS.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;

    // Synchronizer chain plus edge detection against the previous level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], din};
            level_r <= sync_r[SYNC_STAGES-1];
            rise_r  <= sync_r[SYNC_STAGES-1] & ~level_r;
            fall_r  <= ~sync_r[SYNC_STAGES-1] & level_r;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/mmc1_mapper.sv
// MMC1 mapper: serial register loading from CPU writes and registered
// PRG/CHR/nametable address translation.
module mmc1_mapper
    import mmc1_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m2,
    input  logic        cpu_rw,
    input  logic        romsel,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic [13:0] ppu_addr,
    output logic [17:0] prg_addr,
    output logic [16:0] chr_addr,
    output logic        ciram_a10,
    output logic        prg_ram_ce,
    output logic        reg_wr
);

    logic        m2_s, m2_rise_s, m2_fall_s;
    logic [14:0] hold_addr_r;
    logic [7:0]  hold_data_r;
    logic        hold_rw_r, hold_romsel_r;
    logic [4:0]  shift_r, control_r, chr0_r, chr1_r, prg_r;
    logic        rmw_r, reg_wr_r;
    logic [4:0]  commit_s;
    logic [17:0] prg_next_s, prg_addr_r;
    logic [16:0] chr_next_s, chr_addr_r;
    logic        ciram_next_s, ciram_r, ce_next_s, ce_r;
    logic        unused_s;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_m2_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (m2),
        .level (m2_s),
        .rise  (m2_rise_s),
        .fall  (m2_fall_s)
    );

    assign commit_s = {hold_data_r[0], shift_r[4:1]};
    assign unused_s = ^{m2_rise_s, hold_addr_r[12:0], hold_data_r[6:1], ppu_addr[13]};

    // Bus hold capture and the serial load state machine, evaluated on M2 fall
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr_r   <= 15'h0;
            hold_data_r   <= 8'h0;
            hold_rw_r     <= 1'b0;
            hold_romsel_r <= 1'b0;
            shift_r       <= SHIFT_INIT;
            control_r     <= CONTROL_INIT;
            chr0_r        <= 5'h0;
            chr1_r        <= 5'h0;
            prg_r         <= 5'h0;
            rmw_r         <= 1'b0;
            reg_wr_r      <= 1'b0;
        end else begin
            reg_wr_r <= 1'b0;
            if (m2_s) begin
                hold_addr_r   <= cpu_addr;
                hold_data_r   <= cpu_data;
                hold_rw_r     <= cpu_rw;
                hold_romsel_r <= romsel;
            end
            if (m2_fall_s) begin
                if (!hold_romsel_r && !hold_rw_r) begin
                    if (hold_data_r[7]) begin
                        shift_r        <= SHIFT_INIT;
                        control_r[3:2] <= 2'b11;
                        rmw_r          <= 1'b1;
                    end else if (rmw_r) begin
                        // second write of a read-modify-write: dropped, not accepted
                        rmw_r <= 1'b0;
                    end else begin
                        rmw_r <= 1'b1;
                        if (shift_r[0]) begin
                            shift_r  <= SHIFT_INIT;
                            reg_wr_r <= 1'b1;
                            case (reg_idx_e'(hold_addr_r[14:13]))
                                REG_CONTROL: control_r <= commit_s;
                                REG_CHR0:    chr0_r    <= commit_s;
                                REG_CHR1:    chr1_r    <= commit_s;
                                REG_PRG:     prg_r     <= commit_s;
                                default:     prg_r     <= prg_r;
                            endcase
                        end else begin
                            shift_r <= {hold_data_r[0], shift_r[4:1]};
                        end
                    end
                end else begin
                    rmw_r <= 1'b0;
                end
            end
        end
    end

    // Address translation from the live bus and current bank registers
    always_comb begin
        prg_next_s   = 18'h0;
        chr_next_s   = 17'h0;
        ciram_next_s = 1'b0;
        case (prg_mode_e'(control_r[3:2]))
            PRG_FIX_FIRST: begin
                if (cpu_addr[14]) prg_next_s = {prg_r[3:0], cpu_addr[13:0]};
                else              prg_next_s = {4'h0, cpu_addr[13:0]};
            end
            PRG_FIX_LAST: begin
                if (cpu_addr[14]) prg_next_s = {4'hF, cpu_addr[13:0]};
                else              prg_next_s = {prg_r[3:0], cpu_addr[13:0]};
            end
            default: prg_next_s = {prg_r[3:1], cpu_addr[14:0]};
        endcase
        if (control_r[4]) chr_next_s = {(ppu_addr[12] ? chr1_r : chr0_r), ppu_addr[11:0]};
        else              chr_next_s = {chr0_r[4:1], ppu_addr[12:0]};
        case (mirror_e'(control_r[1:0]))
            MIR_ONE_LOW:    ciram_next_s = 1'b0;
            MIR_ONE_HIGH:   ciram_next_s = 1'b1;
            MIR_VERTICAL:   ciram_next_s = ppu_addr[10];
            MIR_HORIZONTAL: ciram_next_s = ppu_addr[11];
            default:        ciram_next_s = 1'b0;
        endcase
        ce_next_s = ~prg_r[4] & romsel & (cpu_addr[14:13] == 2'b11);
    end

    // Output registers: one clock from raw bus to memory address
    always_ff @(posedge clk) begin
        if (rst) begin
            prg_addr_r <= 18'h0;
            chr_addr_r <= 17'h0;
            ciram_r    <= 1'b0;
            ce_r       <= 1'b0;
        end else begin
            prg_addr_r <= prg_next_s;
            chr_addr_r <= chr_next_s;
            ciram_r    <= ciram_next_s;
            ce_r       <= ce_next_s;
        end
    end

    assign prg_addr   = prg_addr_r;
    assign chr_addr   = chr_addr_r;
    assign ciram_a10  = ciram_r;
    assign prg_ram_ce = ce_r;
    assign reg_wr     = reg_wr_r;

endmodule

// File: tb/tb_mmc1_mapper.sv
// Self-checking bench for mmc1_mapper against a bank-arithmetic reference model.
module tb_mmc1_mapper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m2 = 1'b0;
    logic        cpu_rw = 1'b1;
    logic        romsel = 1'b1;
    logic [14:0] cpu_addr = 15'h0;
    logic [7:0]  cpu_data = 8'h0;
    logic [13:0] ppu_addr = 14'h0;
    logic [17:0] prg_addr;
    logic [16:0] chr_addr;
    logic        ciram_a10;
    logic        prg_ram_ce;
    logic        reg_wr;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int exp_wr = 0;
    int m_ctrl, m_chr0, m_chr1, m_prg, m_cnt, m_acc, m_last;

    mmc1_mapper dut (
        .clk(clk), .rst(rst), .m2(m2), .cpu_rw(cpu_rw), .romsel(romsel),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .ppu_addr(ppu_addr),
        .prg_addr(prg_addr), .chr_addr(chr_addr), .ciram_a10(ciram_a10),
        .prg_ram_ce(prg_ram_ce), .reg_wr(reg_wr)
    );

    always #5 clk = ~clk;

    // Count register-commit pulses away from the active edge
    always @(negedge clk) begin
        if (reg_wr === 1'b1) wr_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
        m_cnt = 0; m_acc = 0; m_last = 0;
    endtask

    // Reference behaviour of one completed M2 cycle
    task automatic model_fall(input bit rw, input bit rs, input logic [14:0] a, input logic [7:0] d);
        if (!rs && !rw) begin
            if (d[7]) begin
                m_cnt = 0; m_acc = 0; m_ctrl = m_ctrl | 12; m_last = 1;
            end else if (m_last == 1) begin
                m_last = 0;
            end else begin
                m_acc = m_acc + (int'(d[0]) << m_cnt);
                m_cnt++;
                m_last = 1;
                if (m_cnt == 5) begin
                    case (int'(a[14:13]))
                        0: m_ctrl = m_acc;
                        1: m_chr0 = m_acc;
                        2: m_chr1 = m_acc;
                        default: m_prg = m_acc;
                    endcase
                    exp_wr++;
                    m_cnt = 0; m_acc = 0;
                end
            end
        end else begin
            m_last = 0;
        end
    endtask

    function automatic int exp_prg(input int a);
        int mode;
        mode = (m_ctrl >> 2) & 3;
        if (mode < 2) return ((m_prg >> 1) & 7) * 32768 + a;
        if (mode == 2) return (a < 16384) ? a : (m_prg & 15) * 16384 + (a - 16384);
        return (a < 16384) ? (m_prg & 15) * 16384 + a : 15 * 16384 + (a - 16384);
    endfunction

    function automatic int exp_chr(input int p);
        int q;
        q = p % 8192;
        if (((m_ctrl >> 4) & 1) == 0) return (m_chr0 >> 1) * 8192 + q;
        return ((q >= 4096) ? m_chr1 : m_chr0) * 4096 + (q % 4096);
    endfunction

    function automatic int exp_ciram(input int p);
        case (m_ctrl & 3)
            0: return 0;
            1: return 1;
            2: return (p >> 10) & 1;
            default: return (p >> 11) & 1;
        endcase
    endfunction

    function automatic int exp_ce(input int a, input int rs);
        return (m_prg < 16 && rs == 1 && a >= 24576) ? 1 : 0;
    endfunction

    task automatic m2_cycle(input bit rw, input bit rs, input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_rw = rw; romsel = rs; cpu_addr = a; cpu_data = d; m2 = 1'b1;
        repeat (6) @(negedge clk);
        m2 = 1'b0;
        repeat (6) @(negedge clk);
        model_fall(rw, rs, a, d);
    endtask

    task automatic idle_cycle();
        if ($urandom_range(1) == 1) m2_cycle(1'b1, 1'b0, 15'($urandom), 8'($urandom));
        else m2_cycle(1'b0, 1'b1, 15'h6000 | 15'($urandom_range(8191)), 8'($urandom));
    endtask

    task automatic sw(input logic [14:0] a, input logic [7:0] d);
        m2_cycle(1'b0, 1'b0, a, d);
    endtask

    task automatic write_reg(input logic [14:0] a, input logic [4:0] v);
        for (int i = 0; i < 5; i++) begin
            sw(a, {1'b0, 6'($urandom), v[i]});
            idle_cycle();
        end
    endtask

    task automatic check_outputs(input logic [14:0] a, input logic [13:0] p, input bit rs);
        @(negedge clk);
        cpu_rw = 1'b1; romsel = rs; cpu_addr = a; ppu_addr = p;
        @(negedge clk);
        check("prg_addr", 32'(prg_addr), exp_prg(int'(a)));
        check("chr_addr", 32'(chr_addr), exp_chr(int'(p)));
        check("ciram_a10", 32'(ciram_a10), exp_ciram(int'(p)));
        check("prg_ram_ce", 32'(prg_ram_ce), exp_ce(int'(a), int'(rs)));
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_reg_wr", 32'(reg_wr), 32'h0);
        check_outputs(15'h4000, 14'h0000, 1'b1);
        check("reset_prg_c000", 32'(prg_addr), 32'h3C000);
        check("reset_ciram", 32'(ciram_a10), 32'h0);
        check_outputs(15'h6123, 14'h0C00, 1'b1);

        // PRG bank 5 in fixed-last mode
        write_reg(15'h6000, 5'd5);
        check("wr_after_prg", wr_count, 1);
        check_outputs(15'h0000, 14'h0000, 1'b1);
        check("prg_8000_mode3", 32'(prg_addr), 32'h14000);
        check_outputs(15'h4000, 14'h0000, 1'b1);
        check("prg_c000_mode3", 32'(prg_addr), 32'h3C000);

        // control = 0x12, then chr1 = 3
        write_reg(15'h0000, 5'h12);
        write_reg(15'h4000, 5'd3);
        check_outputs(15'h0000, 14'h1234, 1'b1);
        check("chr_4k_1234", 32'(chr_addr), 32'h03234);
        check("prg_mode0", 32'(prg_addr), 32'h10000);
        check_outputs(15'h2000, 14'h0400, 1'b1);
        check("ciram_vertical", 32'(ciram_a10), 32'h1);

        // back-to-back write pair: second is dropped, commit needs six writes
        sw(15'h6000, 8'h01);
        sw(15'h6000, 8'h00);
        idle_cycle(); sw(15'h6000, 8'h00);
        idle_cycle(); sw(15'h6000, 8'h01);
        idle_cycle(); sw(15'h6000, 8'h01);
        idle_cycle();
        check("rmw_no_commit_at5", wr_count, 3);
        sw(15'h6000, 8'h00);
        idle_cycle();
        check("rmw_commit_at6", wr_count, 4);
        check_outputs(15'h0000, 14'h0000, 1'b1);
        check("rmw_prg13", 32'(prg_addr), 32'h30000);

        // partial load aborted by bit 7
        sw(15'h6000, 8'h01); idle_cycle();
        sw(15'h6000, 8'h01); idle_cycle();
        sw(15'h6000, 8'h01); idle_cycle();
        sw(15'h6000, 8'h80); idle_cycle();
        check("abort_no_wr", wr_count, 4);
        check_outputs(15'h0000, 14'h0000, 1'b1);
        check("abort_mode3", 32'(prg_addr), 32'h34000);
        write_reg(15'h6000, 5'd2);
        check("after_abort_commit", wr_count, 5);
        check_outputs(15'h0000, 14'h0000, 1'b1);

        // reset in the middle of a load
        sw(15'h6000, 8'h01); idle_cycle();
        sw(15'h6000, 8'h01); idle_cycle();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        model_reset();
        write_reg(15'h6000, 5'd9);
        check("rst_mid_commit", wr_count, 6);
        check_outputs(15'h0000, 14'h0000, 1'b1);
        check("rst_mid_prg9", 32'(prg_addr), 32'h24000);

        // randomized register traffic
        for (int it = 0; it < 12; it++) begin
            logic [14:0] ra;
            ra = 15'($urandom);
            if ($urandom_range(3) == 0) begin
                for (int k = 0; k < $urandom_range(3, 1); k++) begin
                    sw(ra, {1'b0, 7'($urandom)}); idle_cycle();
                end
                sw(ra, 8'h80 | 8'($urandom)); idle_cycle();
            end
            write_reg(ra, 5'($urandom));
            check("rand_wr_count", wr_count, exp_wr);
            for (int j = 0; j < 3; j++)
                check_outputs(15'($urandom), 14'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
